fcn_dot_engine: RTL and testbench

- Replaces the fixed-latency FCN stub as the stage directly downstream of cnn_core: on a start pulse it streams the packed int8 feature vector from the 8 L banks and the weight vector from the 8 U banks.
- Computes one signed dot product and raises a one-cycle done with the 32-bit result on out0.
- The accelerator top owns the bank muxing; host access (ena high) overrides the engine's cs/address.

---
 rtl/fcn_pkg.sv | 26 ++
 rtl/mac4_int8.sv | 25 ++
 rtl/fcn_dot_engine.sv | 179 +++++++++++++++++
 tb/tb_fcn_dot_engine.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fcn_pkg.sv
// fcn_pkg
// Shared constants and types for the FCN dot-product engine.
//   N_BANKS / BANK_DEPTH : bank geometry of the L and U feature/weight memories
//   TOTAL_WORDS          : largest vector the banks can hold (N_BANKS * BANK_DEPTH)
//   LANE_W / LANES       : a 32-bit word is four signed int8 lanes
//   state_e              : engine sequencing states
//   lane_word_t          : one packed memory word, lane i in bits [8i+7:8i]
package fcn_pkg;

    localparam int N_BANKS     = 8;
    localparam int BANK_DEPTH  = 36;
    localparam int TOTAL_WORDS = N_BANKS * BANK_DEPTH;
    localparam int LANE_W      = 8;
    localparam int LANES       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_e;

    typedef logic signed [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] lane_word_t;

endpackage

// File: rtl/mac4_int8.sv
// mac4_int8
// Combinational 4-lane signed int8 dot product.
//   a_i, b_i : packed words of four signed int8 lanes
//   sum_o    : 18-bit signed sum of the four 16-bit lane products
module mac4_int8
    import fcn_pkg::*;
(
    input  lane_word_t         a_i,
    input  lane_word_t         b_i,
    output logic signed [17:0] sum_o
);

    logic signed [15:0] prod [LANES];

    // Each product fits 16 bits (worst case -128*-128 = 16384), and four of
    // them fit comfortably in 18 bits, so no intermediate can overflow.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = 16'($signed(a_i[i])) * 16'($signed(b_i[i]));
            sum_o   = sum_o + 18'(prod[i]);
        end
    end

endmodule

// File: rtl/fcn_dot_engine.sv
// fcn_dot_engine
// Streams a packed int8 feature vector (L banks) and weight vector (U banks)
// and produces their signed dot product.
//   clk, rst_ni    : clock, asynchronous active-low reset
//   start          : one-cycle start pulse, ignored unless idle
//   len_words      : words to process, sampled on start, clipped to TOTAL_WORDS
//   mem_cs         : one-hot bank select, same index for L and U
//   mem_addr       : word address within the selected bank
//   q_l, q_u       : bank read data, valid the cycle after mem_cs
//   busy           : high while words are being issued or drained
//   done           : one-cycle pulse when out0 is final
//   out0           : 32-bit result, held until the next accepted start
//   err            : sticky flag set when len_words exceeded TOTAL_WORDS
module fcn_dot_engine
    import fcn_pkg::*;
#(
    parameter int N_BANKS    = fcn_pkg::N_BANKS,
    parameter int BANK_DEPTH = fcn_pkg::BANK_DEPTH,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int RELU       = 0
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic                           start,
    input  logic [8:0]                     len_words,
    output logic [N_BANKS-1:0]             mem_cs,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [N_BANKS-1:0][DATA_W-1:0] q_l,
    input  logic [N_BANKS-1:0][DATA_W-1:0] q_u,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_W-1:0]              out0,
    output logic                           err
);

    localparam int               BANK_W  = $clog2(N_BANKS);
    localparam int               LEN_W   = 9;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(TOTAL_WORDS);

    state_e                   state_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         wordCnt_q;
    logic [BANK_W-1:0]        bank_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [N_BANKS-1:0]       cs_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     err_q;
    logic [DATA_W-1:0]        out0_q;

    logic [BANK_W-1:0]        bankDly_q;
    logic                     bankVld_q;
    logic signed [17:0]       psum_d;
    logic signed [17:0]       psum_q;
    logic                     psumVld_q;
    logic signed [DATA_W-1:0] acc_q;
    logic signed [DATA_W-1:0] acc_d;

    logic [LEN_W-1:0]         lenClip;
    lane_word_t               lWord;
    lane_word_t               uWord;

    assign lenClip = (len_words > MAX_LEN) ? MAX_LEN : len_words;

    assign lWord = q_l[bankDly_q];
    assign uWord = q_u[bankDly_q];

    mac4_int8 u_mac (
        .a_i   (lWord),
        .b_i   (uWord),
        .sum_o (psum_d)
    );

    // The S2 accumulate is also needed combinationally so that the final
    // result can be captured on the same edge as the last accumulate.
    assign acc_d = psumVld_q ? (acc_q + DATA_W'(psum_q)) : acc_q;

    // Sequencer: issues one word per cycle using bank/address counters
    // (address wraps at BANK_DEPTH-1 and the one-hot select shifts), then
    // drains the pipeline. DRAIN leaves as soon as S1 is empty, because the
    // last S2 accumulate lands on that same edge and acc_d already holds it.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            len_q     <= '0;
            wordCnt_q <= '0;
            bank_q    <= '0;
            addr_q    <= '0;
            cs_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            out0_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q     <= lenClip;
                        err_q     <= (len_words > MAX_LEN);
                        out0_q    <= '0;
                        wordCnt_q <= '0;
                        bank_q    <= '0;
                        addr_q    <= '0;
                        if (lenClip == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            cs_q    <= N_BANKS'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (wordCnt_q == len_q - LEN_W'(1)) begin
                        cs_q    <= '0;
                        addr_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        wordCnt_q <= wordCnt_q + LEN_W'(1);
                        if (addr_q == ADDR_W'(BANK_DEPTH - 1)) begin
                            addr_q <= '0;
                            bank_q <= bank_q + BANK_W'(1);
                            cs_q   <= cs_q << 1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!bankVld_q) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        out0_q  <= ((RELU != 0) && acc_d[DATA_W-1]) ? '0 : acc_d;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Datapath: S0 delays the bank index to line up with the synchronous
    // read data, S1 registers the lane sum, S2 accumulates with wrap-around.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            bankDly_q <= '0;
            bankVld_q <= 1'b0;
            psum_q    <= '0;
            psumVld_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            bankDly_q <= bank_q;
            bankVld_q <= (state_q == ISSUE);
            psum_q    <= psum_d;
            psumVld_q <= bankVld_q;
            if ((state_q == IDLE) && start) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    assign mem_cs   = cs_q;
    assign mem_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out0     = out0_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fcn_dot_engine.sv
// tb_fcn_dot_engine
// Directed vectors with hand-computed results for fcn_dot_engine, plus
// hand-written sequences for reset state and a mid-run reset abort.
// A second instance built with RELU=1 sees the same bank data.
module tb_fcn_dot_engine;

    localparam int NB    = 8;
    localparam int DEPTH = 36;
    localparam int AW    = 6;
    localparam int DW    = 32;

    logic                  clk = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  start = 1'b0;
    logic [8:0]            len_words = '0;
    logic [NB-1:0]         mem_cs;
    logic [NB-1:0]         memCsRelu;
    logic [AW-1:0]         mem_addr;
    logic [AW-1:0]         memAddrRelu;
    logic [NB-1:0][DW-1:0] q_l;
    logic [NB-1:0][DW-1:0] q_u;
    logic                  busy, done, err;
    logic                  busyRelu, doneRelu, errRelu;
    logic [DW-1:0]         out0, out0Relu;

    logic [DW-1:0]         memL [NB][DEPTH];
    logic [DW-1:0]         memU [NB][DEPTH];

    int checks = 0;
    int fails  = 0;
    int issueCnt = 0;
    int seqErrs  = 0;
    int busyErrs = 0;

    always #5 clk = ~clk;

    fcn_dot_engine #(.RELU(0)) dut (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .start     (start),
        .len_words (len_words),
        .mem_cs    (mem_cs),
        .mem_addr  (mem_addr),
        .q_l       (q_l),
        .q_u       (q_u),
        .busy      (busy),
        .done      (done),
        .out0      (out0),
        .err       (err)
    );

    fcn_dot_engine #(.RELU(1)) dutRelu (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .start     (start),
        .len_words (len_words),
        .mem_cs    (memCsRelu),
        .mem_addr  (memAddrRelu),
        .q_l       (q_l),
        .q_u       (q_u),
        .busy      (busyRelu),
        .done      (doneRelu),
        .out0      (out0Relu),
        .err       (errRelu)
    );

    // Synchronous-read bank model; unselected banks return junk so a wrong
    // bank index in the engine shows up in the result.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_cs[b] && (int'(mem_addr) < DEPTH)) begin
                q_l[b] <= memL[b][mem_addr];
                q_u[b] <= memU[b][mem_addr];
            end else begin
                q_l[b] <= 32'h5A5A_5A5A + 32'(b);
                q_u[b] <= 32'h3C3C_3C3C + 32'(b);
            end
        end
    end

    // Issue-order monitor: word w must appear as bank w/36, address w%36,
    // and both instances must issue identically.
    always @(negedge clk) begin
        if (memCsRelu !== mem_cs || memAddrRelu !== mem_addr) begin
            seqErrs++;
        end
        if (mem_cs != '0) begin
            if (mem_cs !== (NB'(1) << (issueCnt / DEPTH)) ||
                mem_addr !== AW'(issueCnt % DEPTH)) begin
                seqErrs++;
            end
            issueCnt++;
        end
    end

    typedef struct {
        logic [8:0]  len;
        int          effLen;
        logic [31:0] lVal;
        logic [31:0] uVal;
        bit          lRamp;
        bit          dupStart;
        logic [31:0] expOut;
        logic [31:0] expRelu;
        int          expDone;
        logic        expErr;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic loadMem(input logic [31:0] lVal, input logic [31:0] uVal,
                           input bit lRamp);
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int j;
                j = b * DEPTH + a;
                memL[b][a] = lRamp ? {4{8'(j)}} : lVal;
                memU[b][a] = uVal;
            end
        end
    endtask

    // Start pulse in cycle 0, then sample #1 after each edge until done.
    // busy is checked every cycle against 1..L+2; len_words is scrambled
    // after start to show it is not re-sampled.
    task automatic applyStimulus(input logic [8:0] len, input int effLen,
                                 input bit dupStart, output int doneCycle);
        issueCnt = 0;
        seqErrs  = 0;
        busyErrs = 0;
        doneCycle = -1;
        @(posedge clk);
        #1;
        start     = 1'b1;
        len_words = len;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start     = dupStart && (c == 5);
            len_words = 9'h1FF;
            if (busy !== ((effLen > 0) && (c <= effLen + 2))) begin
                busyErrs++;
            end
            if (done === 1'b1) begin
                doneCycle = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int doneCycle;
        int doneSeen;

        vecs[0] = '{9'd288, 288, 32'h01010101, 32'h01010101, 1'b0, 1'b0,
                    32'd1152, 32'd1152, 291, 1'b0};
        vecs[1] = '{9'd4, 4, 32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b0,
                    32'hFFFFFFE0, 32'h0, 7, 1'b0};
        vecs[2] = '{9'd37, 37, 32'h0, 32'h00000001, 1'b1, 1'b0,
                    32'd666, 32'd666, 40, 1'b0};
        vecs[3] = '{9'd0, 0, 32'h01010101, 32'h01010101, 1'b0, 1'b0,
                    32'h0, 32'h0, 1, 1'b0};
        vecs[4] = '{9'd300, 288, 32'h01010101, 32'h01010101, 1'b0, 1'b0,
                    32'd1152, 32'd1152, 291, 1'b1};
        vecs[5] = '{9'd288, 288, 32'h80808080, 32'h80808080, 1'b0, 1'b1,
                    32'h01200000, 32'h01200000, 291, 1'b0};
        vecs[6] = '{9'd36, 36, 32'h01010101, 32'h01010101, 1'b0, 1'b0,
                    32'd144, 32'd144, 39, 1'b0};
        vecs[7] = '{9'd1, 1, 32'h7F7F7F7F, 32'h81818181, 1'b0, 1'b0,
                    32'hFFFF03FC, 32'h0, 4, 1'b0};

        // Reset state.
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset out0", out0, 32'd0);
        checkOutput("reset mem_cs", 32'(mem_cs), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Table-driven runs.
        for (int v = 0; v < 8; v++) begin
            loadMem(vecs[v].lVal, vecs[v].uVal, vecs[v].lRamp);
            applyStimulus(vecs[v].len, vecs[v].effLen, vecs[v].dupStart, doneCycle);
            $display("[TB] vector %0d len=%0d done at cycle %0d", v, vecs[v].len, doneCycle);
            checkOutput($sformatf("v%0d done cycle", v), 32'(doneCycle), 32'(vecs[v].expDone));
            checkOutput($sformatf("v%0d out0", v), out0, vecs[v].expOut);
            checkOutput($sformatf("v%0d relu out0", v), out0Relu, vecs[v].expRelu);
            checkOutput($sformatf("v%0d err", v), 32'(err), 32'(vecs[v].expErr));
            checkOutput($sformatf("v%0d issues", v), 32'(issueCnt), 32'(vecs[v].effLen));
            checkOutput($sformatf("v%0d issue order", v), 32'(seqErrs), 32'd0);
            checkOutput($sformatf("v%0d busy profile", v), 32'(busyErrs), 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d done width", v), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d out0 hold", v), out0, vecs[v].expOut);
        end

        // Mid-run reset: everything must drop at once, no done afterwards.
        loadMem(32'h01010101, 32'h01010101, 1'b0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        len_words = 9'd300;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        checkOutput("abort pre busy", 32'(busy), 32'd1);
        checkOutput("abort pre err", 32'(err), 32'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort mem_cs", 32'(mem_cs), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort out0", out0, 32'd0);
        checkOutput("abort err", 32'(err), 32'd0);
        doneSeen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || mem_cs !== '0) doneSeen++;
        end
        checkOutput("abort quiet", 32'(doneSeen), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Fresh run after the abort must not carry stale accumulation.
        loadMem(32'hFFFFFFFF, 32'h02020202, 1'b0);
        applyStimulus(9'd4, 4, 1'b0, doneCycle);
        checkOutput("post-abort done cycle", 32'(doneCycle), 32'd7);
        checkOutput("post-abort out0", out0, 32'hFFFFFFE0);
        checkOutput("post-abort relu out0", out0Relu, 32'h0);
        checkOutput("post-abort err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
